// File: rtl/instr_dcd_pkg.sv
// Shared definitions for the SPI command/data instruction decoder.
// State encodings, command byte bit positions and the address field width.
package instr_dcd_pkg;

    typedef enum logic [1:0] {
        ST_CMD      = 2'd0,
        ST_DATA     = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_CAPT  = 2'd3
    } state_t;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_RSVD_BIT = 6;
    localparam int ADDR_FIELD_W = 6;

endpackage

// File: rtl/instr_dcd.sv
// Decodes two-byte SPI frames (command, data) into register read/write strobes.
// Optional INSTR_DCD_BURST_EN: stay in the data phase and auto-increment addr until cs_n rises.
module instr_dcd
    import instr_dcd_pkg::*;
#(
    parameter int ADDR_W = ADDR_FIELD_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_write
);

    state_t state;
    logic   rw;
    logic   read_q;
    logic   write_q;

    // Strobes are registered, but a chip-select abort in the strobe cycle itself must still kill them.
    assign read  = read_q  & ~cs_n;
    assign write = write_q & ~cs_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CMD;
            rw         <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            data_out   <= '0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (cs_n) begin
                state <= ST_CMD;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (byte_sync) begin
                            rw   <= data_in[CMD_RW_BIT];
                            addr <= data_in[ADDR_W-1:0];
                            if (data_in[CMD_RW_BIT]) begin
                                state <= ST_DATA;
                            end else begin
                                state  <= ST_RD_ISSUE;
                                read_q <= 1'b1;
                            end
                        end
                    end
                    // The read strobe is high during this cycle, so data_read is valid at its closing edge.
                    ST_RD_ISSUE: begin
                        data_out <= data_read;
                        state    <= ST_RD_CAPT;
                    end
                    ST_RD_CAPT: begin
                        state <= ST_DATA;
                    end
                    ST_DATA: begin
`ifdef INSTR_DCD_BURST_EN
                        // Advance only once the write has gone out, so it lands on the current address.
                        if (write_q) begin
                            addr <= addr + ADDR_W'(1);
                        end
                        if (byte_sync) begin
                            if (rw) begin
                                data_write <= data_in;
                                write_q    <= 1'b1;
                            end else begin
                                addr   <= addr + ADDR_W'(1);
                                read_q <= 1'b1;
                                state  <= ST_RD_ISSUE;
                            end
                        end
`else
                        if (byte_sync) begin
                            if (rw) begin
                                data_write <= data_in;
                                write_q    <= 1'b1;
                            end
                            state <= ST_CMD;
                        end
`endif
                    end
                    default: begin
                        state <= ST_CMD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_dcd.sv
// Self-checking bench for instr_dcd: random read/write frames against a register-file model.
// Expectations follow INSTR_DCD_BURST_EN when it is defined for the build.
module tb_instr_dcd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;

    logic [7:0] mem [64];
    logic [7:0] exp_dout = 8'h00;

    int errors = 0;
    int checks = 0;
    int rd_count = 0;
    int wr_count = 0;
    int overlap = 0;

    instr_dcd dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_sync(byte_sync),
        .data_in(data_in), .data_out(data_out), .read(read), .write(write),
        .addr(addr), .data_read(data_read), .data_write(data_write)
    );

    always #5 clk = ~clk;

    // The register file answers combinationally for whatever address is presented.
    assign data_read = mem[addr];

    always @(negedge clk) begin
        if (read) rd_count++;
        if (write) wr_count++;
        if (read && write) overlap++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves byte_sync high for exactly one sampling edge; returns 1 time unit after that edge.
    task automatic send_byte(input logic [7:0] b);
        repeat (3) @(posedge clk);
        #1;
        data_in   = b;
        byte_sync = 1'b1;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
    endtask

    task automatic frame_end();
        tick();
        cs_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b want 0", read); end
        checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b want 0", write); end
        checks++; if (addr !== 6'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h want 00", addr); end
        checks++; if (data_write !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_write: got %h want 00", data_write); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h want 00", data_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        for (int i = 0; i < 8; i++) begin
            logic [5:0] a;
            logic [7:0] d;
            logic [7:0] cmd;
            int w0, r0;
            a   = 6'($urandom);
            d   = 8'($urandom);
            cmd = {1'b1, 1'($urandom), a};
            w0  = wr_count;
            r0  = rd_count;
            frame_start();
            send_byte(cmd);
            checks++; if (write !== 1'b0 || read !== 1'b0) begin errors++; $display("[TB] FAIL wr_cmd_quiet: got r=%b w=%b want 0 0", read, write); end
            send_byte(d);
            checks++; if (write !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe: got %b want 1", write); end
            checks++; if (addr !== a) begin errors++; $display("[TB] FAIL wr_addr: got %h want %h", addr, a); end
            checks++; if (data_write !== d) begin errors++; $display("[TB] FAIL wr_data: got %h want %h", data_write, d); end
            tick();
            checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL wr_one_cycle: got %b want 0", write); end
            frame_end();
            checks++; if (wr_count !== w0 + 1 || rd_count !== r0) begin errors++; $display("[TB] FAIL wr_counts: got w=%0d r=%0d want w=%0d r=%0d", wr_count - w0, rd_count - r0, 1, 0); end
            checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL wr_dout_hold: got %h want %h", data_out, exp_dout); end
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 8; i++) begin
            logic [5:0] a;
            logic [7:0] cmd;
            int w0, r0, r_exp;
            a   = 6'($urandom);
            cmd = {1'b0, 1'($urandom), a};
            w0  = wr_count;
            r0  = rd_count;
            frame_start();
            send_byte(cmd);
            checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL rd_strobe: got %b want 1", read); end
            checks++; if (addr !== a) begin errors++; $display("[TB] FAIL rd_addr: got %h want %h", addr, a); end
            tick();
            exp_dout = mem[a];
            checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL rd_one_cycle: got %b want 0", read); end
            checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL rd_data_out: got %h want %h", data_out, exp_dout); end
            send_byte(8'($urandom));
            tick();
            tick();
`ifdef INSTR_DCD_BURST_EN
            exp_dout = mem[(int'(a) + 1) % 64];
            r_exp = 2;
`else
            r_exp = 1;
`endif
            checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL rd_after_data: got %h want %h", data_out, exp_dout); end
            frame_end();
            checks++; if (wr_count !== w0 || rd_count !== r0 + r_exp) begin errors++; $display("[TB] FAIL rd_counts: got w=%0d r=%0d want w=0 r=%0d", wr_count - w0, rd_count - r0, r_exp); end
        end
    endtask

    task automatic test_abort();
        int w0;
        w0 = wr_count;
        frame_start();
        send_byte(8'h85);
        tick();
        cs_n = 1'b1;
        tick();
        tick();
        cs_n = 1'b0;
        send_byte(8'h02);
        checks++; if (read !== 1'b1 || addr !== 6'h02) begin errors++; $display("[TB] FAIL abort_read: got r=%b addr=%h want r=1 addr=02", read, addr); end
        tick();
        exp_dout = mem[2];
        checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL abort_dout: got %h want %h", data_out, exp_dout); end
        send_byte(8'h00);
        tick();
        tick();
`ifdef INSTR_DCD_BURST_EN
        exp_dout = mem[3];
`endif
        frame_end();
        checks++; if (wr_count !== w0) begin errors++; $display("[TB] FAIL abort_no_write: got %0d writes want 0", wr_count - w0); end
    endtask

    task automatic test_collision();
        int w0, r0;
        w0 = wr_count;
        r0 = rd_count;
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        data_in   = 8'h85;
        byte_sync = 1'b1;
        tick();
        byte_sync = 1'b0;
        tick();
        checks++; if (rd_count !== r0 || wr_count !== w0) begin errors++; $display("[TB] FAIL coll_no_strobe: got r=%0d w=%0d want 0 0", rd_count - r0, wr_count - w0); end
        cs_n = 1'b0;
        send_byte(8'h3C);
        checks++; if (read !== 1'b1 || addr !== 6'h3C || write !== 1'b0) begin errors++; $display("[TB] FAIL coll_next_is_cmd: got r=%b w=%b addr=%h want r=1 w=0 addr=3c", read, write, addr); end
        tick();
        exp_dout = mem[6'h3C];
        frame_end();
        checks++; if (wr_count !== w0) begin errors++; $display("[TB] FAIL coll_no_write: got %0d writes want 0", wr_count - w0); end
    endtask

    task automatic test_reset_mid();
        mem[6'h2A] = 8'hC3;
        frame_start();
        send_byte(8'h2A);
        tick();
        checks++; if (data_out !== 8'hC3) begin errors++; $display("[TB] FAIL rst_pre_dout: got %h want c3", data_out); end
        frame_end();
        frame_start();
        send_byte(8'h85);
        rst_n = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00 || addr !== 6'h00 || data_write !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_regs: got dout=%h addr=%h dw=%h want 00 00 00", data_out, addr, data_write); end
        checks++; if (read !== 1'b0 || write !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_strobes: got r=%b w=%b want 0 0", read, write); end
        tick();
        rst_n = 1'b1;
        exp_dout = 8'h00;
        send_byte(8'h11);
        checks++; if (read !== 1'b1 || addr !== 6'h11) begin errors++; $display("[TB] FAIL rst_next_cmd: got r=%b addr=%h want r=1 addr=11", read, addr); end
        tick();
        exp_dout = mem[6'h11];
        checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL rst_next_dout: got %h want %h", data_out, exp_dout); end
        frame_end();
    endtask

    task automatic test_burst();
        frame_start();
        send_byte(8'hBF);
        send_byte(8'h01);
        checks++; if (write !== 1'b1 || addr !== 6'h3F || data_write !== 8'h01) begin errors++; $display("[TB] FAIL burst_first: got w=%b addr=%h dw=%h want 1 3f 01", write, addr, data_write); end
        tick();
        send_byte(8'h02);
`ifdef INSTR_DCD_BURST_EN
        checks++; if (write !== 1'b1 || addr !== 6'h00 || data_write !== 8'h02) begin errors++; $display("[TB] FAIL burst_wrap: got w=%b addr=%h dw=%h want 1 00 02", write, addr, data_write); end
        tick();
`else
        checks++; if (read !== 1'b1 || write !== 1'b0 || addr !== 6'h02) begin errors++; $display("[TB] FAIL single_next_cmd: got r=%b w=%b addr=%h want 1 0 02", read, write, addr); end
        tick();
        exp_dout = mem[2];
`endif
        frame_end();
    endtask

    task automatic test_back_to_back();
        int w_exp, r_exp, w0, r0;
        w0 = wr_count;
        r0 = rd_count;
        w_exp = 0;
        r_exp = 0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] cmd;
            logic [7:0] d;
            cmd = 8'($urandom);
            d   = 8'($urandom);
            cs_n = 1'b0;
            send_byte(cmd);
            if (!cmd[7]) begin
                tick();
                exp_dout = mem[cmd[5:0]];
            end
            send_byte(d);
            if (cmd[7]) begin
                w_exp++;
                checks++; if (write !== 1'b1 || addr !== cmd[5:0] || data_write !== d) begin errors++; $display("[TB] FAIL b2b_write: got w=%b addr=%h dw=%h want 1 %h %h", write, addr, data_write, cmd[5:0], d); end
            end else begin
                r_exp++;
`ifdef INSTR_DCD_BURST_EN
                r_exp++;
                tick();
                exp_dout = mem[(int'(cmd[5:0]) + 1) % 64];
`endif
            end
            tick();
            tick();
            checks++; if (data_out !== exp_dout) begin errors++; $display("[TB] FAIL b2b_dout: got %h want %h", data_out, exp_dout); end
            cs_n = 1'b1;
            tick();
        end
        checks++; if (wr_count - w0 !== w_exp || rd_count - r0 !== r_exp) begin errors++; $display("[TB] FAIL b2b_counts: got w=%0d r=%0d want w=%0d r=%0d", wr_count - w0, rd_count - r0, w_exp, r_exp); end
        checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL strobe_overlap: got %0d want 0", overlap); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[2] = 8'hA5;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_collision();
        test_reset_mid();
        test_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
